// File: rtl/puzzle_scrambler.sv
// rtl/puzzle_scrambler.sv - scrambles the 3x3 sliding-puzzle board with LFSR-chosen legal blank moves
module puzzle_scrambler #(
  parameter int          SCRAMBLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] row1,
  output logic [11:0] row2,
  output logic [11:0] row3,
  output logic [3:0]  blank_pos
);

  typedef enum logic [1:0] {S_IDLE, S_SCRAMBLE, S_DONE} state_t;

  localparam logic [35:0] SOLVED = 36'h123456780;
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] MOVES  = 16'(SCRAMBLE_MOVES);

  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [35:0] board_q, board_d;
  logic [3:0]  blank_q, blank_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  prev_dir_q, prev_dir_d;
  logic        prev_valid_q, prev_valid_d;

  logic [1:0]  dir, row, col;
  logic        legal, reverse;
  logic [3:0]  nb, tile;
  logic [35:0] moved;

  // Position i lives at board[35-4*i -: 4], so {row1,row2,row3} is the board.
  function automatic logic [3:0] get_nib(input logic [35:0] b, input logic [3:0] idx);
    get_nib = 4'h0;
    for (int i = 0; i < 9; i++) begin
      if (4'(i) == idx) get_nib = b[35-4*i -: 4];
    end
  endfunction

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    dir    = lfsr_q[1:0];

    case (blank_q)
      4'd0:    {row, col} = {2'd0, 2'd0};
      4'd1:    {row, col} = {2'd0, 2'd1};
      4'd2:    {row, col} = {2'd0, 2'd2};
      4'd3:    {row, col} = {2'd1, 2'd0};
      4'd4:    {row, col} = {2'd1, 2'd1};
      4'd5:    {row, col} = {2'd1, 2'd2};
      4'd6:    {row, col} = {2'd2, 2'd0};
      4'd7:    {row, col} = {2'd2, 2'd1};
      default: {row, col} = {2'd2, 2'd2};
    endcase

    case (dir)
      DIR_L:   begin legal = (col != 2'd0); nb = blank_q - 4'd1; end
      DIR_R:   begin legal = (col != 2'd2); nb = blank_q + 4'd1; end
      DIR_U:   begin legal = (row != 2'd0); nb = blank_q - 4'd3; end
      default: begin legal = (row != 2'd2); nb = blank_q + 4'd3; end
    endcase

    // L/R and U/D pairs differ only in bit 0.
    reverse = prev_valid_q && (dir == {prev_dir_q[1], ~prev_dir_q[0]});
    tile    = get_nib(board_q, nb);

    moved = board_q;
    for (int i = 0; i < 9; i++) begin
      if (4'(i) == blank_q)  moved[35-4*i -: 4] = tile;
      else if (4'(i) == nb)  moved[35-4*i -: 4] = 4'h0;
    end
  end

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    blank_d      = blank_q;
    remaining_d  = remaining_q;
    prev_dir_d   = prev_dir_q;
    prev_valid_d = prev_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          board_d      = SOLVED;
          blank_d      = 4'd8;
          remaining_d  = MOVES;
          prev_valid_d = 1'b0;
          state_d      = S_SCRAMBLE;
        end
      end
      S_SCRAMBLE: begin
        if (remaining_q == 16'd0) begin
          state_d = S_DONE;
        end else if (legal && !reverse) begin
          board_d      = moved;
          blank_d      = nb;
          prev_dir_d   = dir;
          prev_valid_d = 1'b1;
          remaining_d  = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      board_q      <= SOLVED;
      blank_q      <= 4'd8;
      remaining_q  <= 16'd0;
      prev_dir_q   <= 2'b00;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      board_q      <= board_d;
      blank_q      <= blank_d;
      remaining_q  <= remaining_d;
      prev_dir_q   <= prev_dir_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign busy      = (state_q == S_SCRAMBLE);
  assign done      = (state_q == S_DONE);
  assign row1      = board_q[35:24];
  assign row2      = board_q[23:12];
  assign row3      = board_q[11:0];
  assign blank_pos = blank_q;

endmodule

// File: tb/tb_puzzle_scrambler.sv
// tb/tb_puzzle_scrambler.sv - self-checking bench for puzzle_scrambler
module tb_puzzle_scrambler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st  [4];
  logic        bsy [4];
  logic        dn  [4];
  logic [11:0] r1  [4];
  logic [11:0] r2  [4];
  logic [11:0] r3  [4];
  logic [3:0]  bp  [4];

  always #5 clk = ~clk;

  puzzle_scrambler #(.SCRAMBLE_MOVES(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .busy(bsy[0]), .done(dn[0]),
    .row1(r1[0]), .row2(r2[0]), .row3(r3[0]), .blank_pos(bp[0]));
  puzzle_scrambler #(.SCRAMBLE_MOVES(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .busy(bsy[1]), .done(dn[1]),
    .row1(r1[1]), .row2(r2[1]), .row3(r3[1]), .blank_pos(bp[1]));
  puzzle_scrambler #(.SCRAMBLE_MOVES(3)) u_m3 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .busy(bsy[2]), .done(dn[2]),
    .row1(r1[2]), .row2(r2[2]), .row3(r3[2]), .blank_pos(bp[2]));
  puzzle_scrambler #(.SCRAMBLE_MOVES(64)) u_m64 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .busy(bsy[3]), .done(dn[3]),
    .row1(r1[3]), .row2(r2[3]), .row3(r3[3]), .blank_pos(bp[3]));

  typedef struct {
    int          inst;
    int          cyc;
    logic [11:0] e1, e2, e3;
    logic [3:0]  ebp;
    logic        ebusy, edone;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int i, input int c, input logic [11:0] a, input logic [11:0] b,
                     input logic [11:0] d, input logic [3:0] p, input logic by, input logic dne);
    vec_t v;
    v.inst = i; v.cyc = c; v.e1 = a; v.e2 = b; v.e3 = d; v.ebp = p; v.ebusy = by; v.edone = dne;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0] getn(input logic [35:0] b, input int i);
    return b[35-4*i -: 4];
  endfunction

  // Scoreboard for the 64-move instance: invariants and move legality every cycle.
  logic        mon_en = 1'b0;
  logic        pbusy;
  logic [35:0] pboard, board;
  logic [3:0]  pbp;
  int          moves, scr_done, pdir, dir, diffs, d;
  logic        have_prev, okv;
  logic [8:0]  mask;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      board = {r1[3], r2[3], r3[3]};
      mask = 9'h0; okv = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if (getn(board, i) > 4'd8) okv = 1'b0;
        else mask[getn(board, i)] = 1'b1;
      end
      chk("perm", {63'h0, okv && (mask == 9'h1FF)}, 64'h1);
      chk("blank_zero", {60'h0, (bp[3] < 4'd9) ? getn(board, int'(bp[3])) : 4'hF}, 64'h0);
      if (!pbusy && bsy[3]) begin
        chk("accept_solved", {24'h0, board, bp[3]}, {24'h0, 36'h123456780, 4'd8});
        moves = 0; have_prev = 1'b0;
      end else if (pbusy) begin
        if (board != pboard) begin
          diffs = 0;
          for (int i = 0; i < 9; i++) if (getn(board, i) != getn(pboard, i)) diffs++;
          chk("two_nibbles", 64'(diffs), 64'd2);
          d = int'(bp[3]) - int'(pbp);
          case (d)
            -1:      dir = (pbp % 3 != 0) ? 0 : -1;
            1:       dir = (pbp % 3 != 2) ? 1 : -1;
            -3:      dir = 2;
            3:       dir = 3;
            default: dir = -1;
          endcase
          chk("legal_step", {63'h0, dir >= 0}, 64'h1);
          if (have_prev && dir >= 0)
            chk("no_backtrack", {63'h0, dir == (pdir ^ 1)}, 64'h0);
          moves++; pdir = dir; have_prev = 1'b1;
        end
      end else begin
        chk("idle_hold", {24'h0, board, bp[3]}, {24'h0, pboard, pbp});
      end
      if (dn[3]) begin
        chk("move_count", 64'(moves), 64'd64);
        scr_done++;
      end
      pbusy = bsy[3]; pboard = board; pbp = bp[3];
    end
  end

  logic got;

  initial begin
    scr_done = 0; moves = 0; have_prev = 1'b0; pdir = 0;
    rst_n = 1'b0;
    st[0] = 1'b1; st[1] = 1'b1; st[2] = 1'b1; st[3] = 1'b0;

    // M3 walkthrough with default seed: L, L, skip, U.
    add(2, 0, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0);
    add(2, 1, 12'h123, 12'h456, 12'h780, 4'd8, 1'b1, 1'b0);
    add(2, 2, 12'h123, 12'h456, 12'h708, 4'd7, 1'b1, 1'b0);
    add(2, 3, 12'h123, 12'h456, 12'h078, 4'd6, 1'b1, 1'b0);
    add(2, 4, 12'h123, 12'h456, 12'h078, 4'd6, 1'b1, 1'b0);
    add(2, 5, 12'h123, 12'h056, 12'h478, 4'd3, 1'b0, 1'b1);
    add(2, 6, 12'h123, 12'h056, 12'h478, 4'd3, 1'b0, 1'b0);
    add(1, 0, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0);
    add(1, 1, 12'h123, 12'h456, 12'h780, 4'd8, 1'b1, 1'b0);
    add(1, 2, 12'h123, 12'h456, 12'h708, 4'd7, 1'b0, 1'b1);
    add(1, 3, 12'h123, 12'h456, 12'h708, 4'd7, 1'b0, 1'b0);
    add(1, 6, 12'h123, 12'h456, 12'h708, 4'd7, 1'b0, 1'b0);
    add(0, 0, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0);
    add(0, 1, 12'h123, 12'h456, 12'h780, 4'd8, 1'b1, 1'b0);
    add(0, 2, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b1);
    add(0, 3, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0);
    add(0, 6, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0);
    add(3, 6, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0; end
      foreach (vecs[k]) begin
        if (vecs[k].cyc == c) begin
          int i;
          i = vecs[k].inst;
          chk($sformatf("vec_inst%0d_cyc%0d", i, c),
              {22'h0, r1[i], r2[i], r3[i], bp[i], bsy[i], dn[i]},
              {22'h0, vecs[k].e1, vecs[k].e2, vecs[k].e3, vecs[k].ebp, vecs[k].ebusy, vecs[k].edone});
        end
      end
    end

    // Start pulsed while busy on M3: one done pulse, then it stays idle.
    st[2] = 1'b1; @(negedge clk); st[2] = 1'b0;
    @(negedge clk); st[2] = 1'b1; @(negedge clk); st[2] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (dn[2]) got = 1'b1; else @(negedge clk);
    end
    chk("m3_done_seen", {63'h0, got}, 64'h1);
    repeat (3) begin
      @(negedge clk);
      chk("m3_idle_after", {62'h0, bsy[2], dn[2]}, 64'h0);
    end

    // Reset in the middle of a 64-move scramble.
    st[3] = 1'b1; @(negedge clk); st[3] = 1'b0;
    repeat (10) @(negedge clk);
    chk("m64_busy_mid", {63'h0, bsy[3]}, 64'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {22'h0, r1[3], r2[3], r3[3], bp[3], bsy[3], dn[3]},
           {22'h0, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {22'h0, r1[3], r2[3], r3[3], bp[3], bsy[3], dn[3]},
        {22'h0, 12'h123, 12'h456, 12'h780, 4'd8, 1'b0, 1'b0});

    // Random scrambles with the scoreboard running.
    pboard = {r1[3], r2[3], r3[3]}; pbp = bp[3]; pbusy = bsy[3];
    mon_en = 1'b1;
    for (int s = 0; s < 200; s++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      st[3] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 3000 && !got; c++) begin
        @(negedge clk);
        if (dn[3]) got = 1'b1;
        else st[3] = 1'($urandom_range(0, 1));
      end
      st[3] = 1'b0;
      chk("scramble_done", {63'h0, got}, 64'h1);
      if (!got) break;
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("scramble_total", 64'(scr_done), 64'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
